// File: rtl/irda_pkg.sv
// -----------------------------------------------------------------------------
// irda_pkg
// Shared types and constants for the IrDA/UART serial link (RX and TX sides).
//   rx_state_t        : receive frame FSM states
//   OVS               : oversample ticks per bit
//   MID_SAMPLE        : sample-counter value at mid-bit (NRZ sampling point)
//   DATA_BITS         : payload bits per frame
//   FRAME_BITS        : start + data + parity + 2 stop
//   DEFAULT_BAUD_DIV  : clk cycles per oversample tick
//   frame_parity()    : parity bit a transmitter sends for a byte
// -----------------------------------------------------------------------------
package irda_pkg;

  localparam int OVS              = 16;
  localparam int MID_SAMPLE       = 7;
  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS       = 12;
  localparam int DEFAULT_BAUD_DIV = 27;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_t;

  // Parity bit that makes the total number of ones even (odd=0) or odd (odd=1).
  function automatic logic frame_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/irda_baud_tick.sv
// -----------------------------------------------------------------------------
// irda_baud_tick
// Oversample tick divider, shared by the RX and TX sides of the link.
// Counts 0..DIV-1 and pulses tick_o for one clk at the wrap. clear_i holds the
// counter at 0 and suppresses the tick, so the first tick after clear_i drops
// comes exactly DIV clks later.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   clear_i  in   synchronous counter clear
//   tick_o   out  one-clk pulse every DIV clks
// -----------------------------------------------------------------------------
module irda_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = 12;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap   = (cnt_q == CW'(DIV - 1));
  assign tick_o = wrap & ~clear_i;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/irda_rx_frame.sv
// -----------------------------------------------------------------------------
// irda_rx_frame
// Receive side of the IrDA/UART link. Oversamples rxd at 16x bit rate,
// aligns to the start edge and deserialises start(0), 8 data LSB-first,
// parity, 2 stop(1). Each completed frame gives a one-clk rx_valid strobe with
// the byte plus parity and framing error flags (strobe fires even on error).
// Build option:
//   IRDA_PULSE_EN  rxd carries IrDA SIR pulses; a bit is 0 when a low pulse
//                  was seen during its bit period, evaluated at the end of the
//                  bit (sc==15). Undefined: plain NRZ mid-bit sampling.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   rxd         in   asynchronous serial line, idle high
//   rx_data     out  last received byte
//   rx_valid    out  one-clk frame-complete strobe
//   parity_err  out  parity mismatch on last frame
//   frame_err   out  a stop bit sampled 0 on last frame
//   busy        out  high while a frame is in progress
// -----------------------------------------------------------------------------
module irda_rx_frame
  import irda_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

`ifdef IRDA_PULSE_EN
  localparam logic [3:0] EVAL_SC = 4'(OVS - 1);
`else
  localparam logic [3:0] EVAL_SC = 4'(MID_SAMPLE);
`endif

  rx_state_t   state_q, state_d;
  logic        sync1_q, rxs_q, rxs_prev_q;
  logic [3:0]  sc_q, sc_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        p_err_q, p_err_d;
  logic        s1_q, s1_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;

  logic        tick;
  logic        fall;
  logic        sample_now;
  logic        bit_val;

  // Tick divider is held clear while idle so the first tick lands BAUD_DIV
  // clks after the start edge and mid-bit falls on sc==7.
  irda_baud_tick #(
    .DIV (BAUD_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q == IDLE),
    .tick_o  (tick)
  );

  // Start detection is edge-qualified: a line stuck low (break) cannot
  // retrigger a frame until it has gone high and fallen again.
  assign fall       = rxs_prev_q & ~rxs_q;
  assign sample_now = tick && (sc_q == EVAL_SC);

`ifdef IRDA_PULSE_EN
  logic seen_low_q, seen_low_d;

  assign bit_val = ~seen_low_q;

  // Per-bit pulse latch. On the evaluation tick the current sample already
  // belongs to the next bit period, so it is not folded in.
  always_comb begin
    seen_low_d = seen_low_q;
    if (state_q == IDLE) begin
      seen_low_d = fall;
    end else if (state_q == STOP2 && sample_now && fall) begin
      seen_low_d = 1'b1;
    end else if (tick) begin
      if (sc_q == 4'(OVS - 1)) begin
        seen_low_d = 1'b0;
      end else if (!rxs_q) begin
        seen_low_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_low_q <= 1'b0;
    end else begin
      seen_low_q <= seen_low_d;
    end
  end
`else
  assign bit_val = rxs_q;
`endif

  always_comb begin
    state_d      = state_q;
    sc_d         = sc_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    p_err_d      = p_err_q;
    s1_d         = s1_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (state_q == IDLE) begin
      sc_d = '0;
    end else if (tick) begin
      sc_d = sc_q + 4'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
        end
      end
      START: begin
        if (sample_now) begin
          if (!bit_val) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (sample_now) begin
          shreg_d = {bit_val, shreg_q[7:1]};
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (sample_now) begin
          p_err_d = bit_val ^ frame_parity(shreg_q, PARITY_ODD);
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (sample_now) begin
          s1_d    = bit_val;
          state_d = STOP2;
        end
      end
      STOP2: begin
        if (sample_now) begin
          state_d      = IDLE;
          rx_valid_d   = 1'b1;
          rx_data_d    = shreg_q;
          parity_err_d = p_err_q;
          frame_err_d  = ~(s1_q & bit_val);
`ifdef IRDA_PULSE_EN
          // End-of-bit evaluation coincides with the next frame's start
          // pulse when frames are back-to-back; the divider and sc have just
          // wrapped, so the new frame is already aligned.
          if (fall) begin
            state_d = START;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      state_q      <= IDLE;
      sc_q         <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      p_err_q      <= 1'b0;
      s1_q         <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= rxd;
      rxs_q        <= sync1_q;
      rxs_prev_q   <= rxs_q;
      state_q      <= state_d;
      sc_q         <= sc_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      p_err_q      <= p_err_d;
      s1_q         <= s1_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_irda_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_irda_rx_frame
// Directed bench for irda_rx_frame. Frames are driven bit by bit (NRZ, or
// IrDA 3/16-bit pulses when IRDA_PULSE_EN is defined); every strobe is
// captured and compared against hand-computed bytes and flags.
// -----------------------------------------------------------------------------
module tb_irda_rx_frame;
  import irda_pkg::*;

  localparam int BD      = 4;
  localparam bit PAR_ODD = 1'b0;
  localparam int BIT_CLK = OVS * BD;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  int         n_strobe = 0;
  logic [7:0] cap_data [0:15];
  logic       cap_pe   [0:15];
  logic       cap_fe   [0:15];

  always #5 clk = ~clk;

  irda_rx_frame #(
    .BAUD_DIV   (BD),
    .PARITY_ODD (PAR_ODD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Capture every strobe; a strobe longer than one clk shows up as extra
  // captures and breaks the strobe count checks.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (n_strobe < 16) begin
        cap_data[n_strobe] <= rx_data;
        cap_pe[n_strobe]   <= parity_err;
        cap_fe[n_strobe]   <= frame_err;
      end
      n_strobe <= n_strobe + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
`ifdef IRDA_PULSE_EN
    if (!b) begin
      rxd = 1'b0;
      repeat (3 * BD) @(negedge clk);
      rxd = 1'b1;
      repeat (13 * BD) @(negedge clk);
    end else begin
      rxd = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end
`else
    rxd = b;
    repeat (BIT_CLK) @(negedge clk);
`endif
  endtask

  task automatic send_frame(input string tag, input logic [7:0] d, input logic flip,
                            input logic s1, input logic s2);
    logic par;
    par = (^d) ^ PAR_ODD ^ flip;
    send_bit(1'b0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(s1);
    send_bit(s2);
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * BIT_CLK) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [7:0] d,
                             input logic pe, input logic fe);
    chk({tag, "_data"}, 32'(cap_data[idx]), 32'(d));
    chk({tag, "_perr"}, 32'(cap_pe[idx]), 32'(pe));
    chk({tag, "_ferr"}, 32'(cap_fe[idx]), 32'(fe));
    $display("[TB] frame %s: data=0x%02h perr=%0b ferr=%0b", tag, cap_data[idx],
             cap_pe[idx], cap_fe[idx]);
  endtask

  initial begin
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_data",  32'(rx_data),    32'h0);
    chk("rst_valid", 32'(rx_valid),   32'h0);
    chk("rst_perr",  32'(parity_err), 32'h0);
    chk("rst_ferr",  32'(frame_err),  32'h0);
    chk("rst_busy",  32'(busy),       32'h0);
    $display("[TB] reset state checked");
    idle_bits(1);

    // Good frame
    send_frame("a5", 8'hA5, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    chk("a5_count", 32'(n_strobe), 32'd1);
    chk("a5_idle",  32'(busy), 32'd0);
    check_frame("a5", 0, 8'hA5, 1'b0, 1'b0);

    // Parity bit inverted
    send_frame("3c", 8'h3C, 1'b1, 1'b1, 1'b1);
    idle_bits(2);
    chk("3c_count", 32'(n_strobe), 32'd2);
    check_frame("3c", 1, 8'h3C, 1'b1, 1'b0);

    // Stop2 low, then a good frame clears the flag
    send_frame("81", 8'h81, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    chk("81_count", 32'(n_strobe), 32'd3);
    check_frame("81", 2, 8'h81, 1'b0, 1'b1);
    send_frame("55", 8'h55, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    chk("55_count", 32'(n_strobe), 32'd4);
    check_frame("55", 3, 8'h55, 1'b0, 1'b0);

`ifndef IRDA_PULSE_EN
    // 4-tick glitch on the idle line: start rejected at mid-bit
    rxd = 1'b0;
    repeat (4 * BD) @(negedge clk);
    chk("glitch_busy", 32'(busy), 32'd1);
    idle_bits(2);
    chk("glitch_idle",  32'(busy), 32'd0);
    chk("glitch_count", 32'(n_strobe), 32'd4);
    chk("glitch_data",  32'(rx_data), 32'h55);
    $display("[TB] glitch rejected");
`endif

    // Reset during data bit 4 of a 0x7E frame
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rxd = 1'b1;
    repeat (8 * BD) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_data", 32'(rx_data), 32'h0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_perr", 32'(parity_err), 32'd0);
    chk("mrst_ferr", 32'(frame_err), 32'd0);
    reset = 1'b0;
    idle_bits(2);
    chk("mrst_count", 32'(n_strobe), 32'd4);
    $display("[TB] mid-frame reset checked");
    send_frame("7e", 8'h7E, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    chk("7e_count", 32'(n_strobe), 32'd5);
    check_frame("7e", 4, 8'h7E, 1'b0, 1'b0);

    // Back-to-back frames, no idle gap
    send_frame("b2b00", 8'h00, 1'b0, 1'b1, 1'b1);
    send_frame("b2bff", 8'hFF, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    chk("b2b_count", 32'(n_strobe), 32'd7);
    check_frame("b2b00", 5, 8'h00, 1'b0, 1'b0);
    check_frame("b2bff", 6, 8'hFF, 1'b0, 1'b0);

    // Break: line held low for longer than a frame, then released
    rxd = 1'b0;
    repeat ((FRAME_BITS + 2) * BIT_CLK) @(negedge clk);
    chk("brk_count_low", 32'(n_strobe), 32'd8);
    idle_bits(3);
    chk("brk_count", 32'(n_strobe), 32'd8);
    chk("brk_idle",  32'(busy), 32'd0);
    check_frame("brk", 7, 8'h00, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
